// File: rtl/winner_screen_anim.sv
// rtl/winner_screen_anim.sv - animated end-of-game result screen for player and PC boards
module winner_screen_anim #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int CW        = 3,
    parameter int TICK_DIV  = 4,
    parameter int BLINKS    = 3,
    parameter int BLINK_LEN = 8,
    parameter int C_WIN     = 3,
    parameter int C_LOSE    = 2,
    parameter int C_DRAW    = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               result,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic [ROWS*COLS*CW-1:0]  matrix_player,
    output logic [ROWS*COLS*CW-1:0]  matrix_pc
);

    localparam int N  = ROWS * COLS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BW = (BLINK_LEN > 1) ? $clog2(BLINK_LEN) : 1;
    localparam int HW = (BLINKS > 0) ? $clog2(2 * BLINKS) : 1;
    localparam bit HAS_BLINK = (BLINKS > 0);

    localparam logic [CW-1:0] CODE_WIN  = CW'(C_WIN);
    localparam logic [CW-1:0] CODE_LOSE = CW'(C_LOSE);
    localparam logic [CW-1:0] CODE_DRAW = CW'(C_DRAW);

    typedef enum logic [2:0] {IDLE, CLEAR, FILL, BLINK, FIN} state_t;

    state_t         state, state_next;
    logic [1:0]     res;
    logic [IW-1:0]  idx;
    logic [TW-1:0]  tick;
    logic [BW-1:0]  blen;
    logic [HW-1:0]  half;

    logic           tick_last, idx_last, blen_last, half_last, blink_en;
    logic           accept, do_abort, do_clear, do_write, do_toggle, do_done;
    logic [CW-1:0]  code_player, code_pc;

    assign tick_last = (tick == TW'(TICK_DIV - 1));
    assign idx_last  = (idx == IW'(N - 1));
    assign blen_last = (blen == BW'(BLINK_LEN - 1));
    assign half_last = (half == HW'(2 * BLINKS - 1));
    assign blink_en  = HAS_BLINK && (res != 2'd3);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic: abort wins over everything while the animation runs
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = CLEAR;
            CLEAR: state_next = (res == 2'd0) ? IDLE : FILL;
            FILL: begin
                if (abort)                      state_next = IDLE;
                else if (tick_last && idx_last) state_next = blink_en ? BLINK : FIN;
            end
            BLINK: begin
                if (abort)                       state_next = IDLE;
                else if (blen_last && half_last) state_next = FIN;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control strobes and per-result cell colours
    always_comb begin
        accept    = (state == IDLE) && start;
        do_abort  = abort && busy;
        do_clear  = (state == CLEAR) || do_abort;
        do_write  = (state == FILL) && tick_last && !abort;
        do_toggle = (state == BLINK) && blen_last && !abort;
        do_done   = (state == FIN) && !abort;
        case (res)
            2'd1:    begin code_player = CODE_WIN;  code_pc = CODE_LOSE; end
            2'd2:    begin code_player = CODE_LOSE; code_pc = CODE_WIN;  end
            default: begin code_player = CODE_DRAW; code_pc = CODE_DRAW; end
        endcase
    end

    // Datapath: result latch, counters, status flags and the two board images
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res           <= '0;
            idx           <= '0;
            tick          <= '0;
            blen          <= '0;
            half          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            matrix_player <= '0;
            matrix_pc     <= '0;
        end else begin
            if (accept) res <= result;

            done <= do_done || ((state == CLEAR) && (res == 2'd0));

            if (state == CLEAR)            busy <= (res != 2'd0);
            else if (do_done || do_abort)  busy <= 1'b0;

            tick <= ((state == FILL) && !tick_last && !abort) ? tick + 1'b1 : '0;

            if ((state != FILL) || do_abort) idx <= '0;
            else if (do_write)               idx <= idx_last ? '0 : idx + 1'b1;

            blen <= ((state == BLINK) && !blen_last && !abort) ? blen + 1'b1 : '0;

            if ((state != BLINK) || do_abort) half <= '0;
            else if (do_toggle)               half <= half_last ? '0 : half + 1'b1;

            if (do_clear) begin
                matrix_player <= '0;
                matrix_pc     <= '0;
            end else if (do_write) begin
                matrix_player[idx*CW +: CW] <= code_player;
                matrix_pc[idx*CW +: CW]     <= code_pc;
            end else if (do_toggle) begin
                // half[0]==0 marks an odd toggle: winner goes dark
                if (res == 2'd1) matrix_player <= half[0] ? {N{CODE_WIN}} : '0;
                else             matrix_pc     <= half[0] ? {N{CODE_WIN}} : '0;
            end
        end
    end

endmodule

// File: tb/tb_winner_screen_anim.sv
// tb/tb_winner_screen_anim.sv - scoreboard bench for winner_screen_anim
module tb_winner_screen_anim;

    localparam int N   = 25;
    localparam int CW  = 3;
    localparam int MW  = N * CW;
    localparam int TD  = 4;
    localparam int NB  = 3;
    localparam int BL  = 8;

    typedef struct {
        int            edge_no;
        logic [MW-1:0] mp;
        logic [MW-1:0] mc;
        logic          busy;
        logic          done;
    } snap_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    result;
    logic          abort;
    logic          busy;
    logic          done;
    logic [MW-1:0] matrix_player;
    logic [MW-1:0] matrix_pc;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    k = 0;
    snap_t sb[$];

    winner_screen_anim dut (
        .clk(clk), .rst_n(rst_n), .start(start), .result(result), .abort(abort),
        .busy(busy), .done(done), .matrix_player(matrix_player), .matrix_pc(matrix_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected screen e edges after the start edge k, straight from the timing formulas
    function automatic snap_t model(input int res, input int e);
        snap_t s;
        int cnt, f, d, t;
        logic [CW-1:0] cp, cc;
        s.edge_no = e;
        s.mp = '0;
        s.mc = '0;
        s.busy = 1'b0;
        s.done = 1'b0;
        if (res == 0) begin
            s.done = (e == 1);
            return s;
        end
        cp = (res == 1) ? 3'd3 : (res == 2) ? 3'd2 : 3'd1;
        cc = (res == 1) ? 3'd2 : (res == 2) ? 3'd3 : 3'd1;
        cnt = (e - 1) / TD;
        if (cnt > N) cnt = N;
        for (int j = 0; j < cnt; j++) begin
            s.mp[j*CW +: CW] = cp;
            s.mc[j*CW +: CW] = cc;
        end
        f = 1 + N * TD;
        d = f + ((res == 3) ? 0 : 2 * NB * BL) + 1;
        if (res != 3 && e > f) begin
            t = (e - f) / BL;
            if (t > 2 * NB) t = 2 * NB;
            if (t % 2 == 1) begin
                if (res == 1) s.mp = '0;
                else          s.mc = '0;
            end
        end
        s.busy = (e >= 1) && (e < d);
        s.done = (e == d);
        return s;
    endfunction

    task automatic push_run(input int res, input int first, input int last);
        for (int e = first; e <= last; e++) sb.push_back(model(res, e));
    endtask

    task automatic kick(input logic [1:0] r);
        @(negedge clk);
        result = r;
        start  = 1'b1;
        k      = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; result = 2'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (matrix_player !== '0) begin errors++; $display("FAIL reset_player got %h want 0", matrix_player); end
        checks++; if (matrix_pc !== '0) begin errors++; $display("FAIL reset_pc got %h want 0", matrix_pc); end
    endtask

    task automatic test_player_win;
        snap_t s;
        kick(2'd1);
        push_run(1, 1, 152);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            while (cyc - k < s.edge_no) @(negedge clk);
            checks++; if (matrix_player !== s.mp) begin errors++; $display("FAIL win1_player e=%0d got %h want %h", s.edge_no, matrix_player, s.mp); end
            checks++; if (matrix_pc !== s.mc) begin errors++; $display("FAIL win1_pc e=%0d got %h want %h", s.edge_no, matrix_pc, s.mc); end
            checks++; if (busy !== s.busy) begin errors++; $display("FAIL win1_busy e=%0d got %b want %b", s.edge_no, busy, s.busy); end
            checks++; if (done !== s.done) begin errors++; $display("FAIL win1_done e=%0d got %b want %b", s.edge_no, done, s.done); end
        end
    endtask

    task automatic test_clear;
        snap_t s;
        kick(2'd0);
        push_run(0, 1, 3);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            while (cyc - k < s.edge_no) @(negedge clk);
            checks++; if (matrix_player !== s.mp) begin errors++; $display("FAIL clear_player e=%0d got %h want %h", s.edge_no, matrix_player, s.mp); end
            checks++; if (matrix_pc !== s.mc) begin errors++; $display("FAIL clear_pc e=%0d got %h want %h", s.edge_no, matrix_pc, s.mc); end
            checks++; if (busy !== s.busy) begin errors++; $display("FAIL clear_busy e=%0d got %b want %b", s.edge_no, busy, s.busy); end
            checks++; if (done !== s.done) begin errors++; $display("FAIL clear_done e=%0d got %b want %b", s.edge_no, done, s.done); end
        end
    endtask

    // Draw run; at the done cycle a result-1 start is issued and must be accepted
    task automatic test_back_to_back;
        snap_t s;
        int k2;
        kick(2'd3);
        push_run(3, 1, 102);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            while (cyc - k < s.edge_no) @(negedge clk);
            checks++; if (matrix_player !== s.mp) begin errors++; $display("FAIL draw_player e=%0d got %h want %h", s.edge_no, matrix_player, s.mp); end
            checks++; if (matrix_pc !== s.mc) begin errors++; $display("FAIL draw_pc e=%0d got %h want %h", s.edge_no, matrix_pc, s.mc); end
            checks++; if (busy !== s.busy) begin errors++; $display("FAIL draw_busy e=%0d got %b want %b", s.edge_no, busy, s.busy); end
            checks++; if (done !== s.done) begin errors++; $display("FAIL draw_done e=%0d got %b want %b", s.edge_no, done, s.done); end
        end
        result = 2'd1;
        start  = 1'b1;
        k2     = cyc + 1;
        @(negedge clk);
        start  = 1'b0;
        k      = k2;
        push_run(1, 1, 12);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            while (cyc - k < s.edge_no) @(negedge clk);
            checks++; if (matrix_player !== s.mp) begin errors++; $display("FAIL b2b_player e=%0d got %h want %h", s.edge_no, matrix_player, s.mp); end
            checks++; if (matrix_pc !== s.mc) begin errors++; $display("FAIL b2b_pc e=%0d got %h want %h", s.edge_no, matrix_pc, s.mc); end
            checks++; if (busy !== s.busy) begin errors++; $display("FAIL b2b_busy e=%0d got %b want %b", s.edge_no, busy, s.busy); end
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    // PC win with a second start (carrying result=1) mid-run that must be ignored
    task automatic test_restart_ignored;
        snap_t s;
        kick(2'd2);
        push_run(2, 1, 152);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            while (cyc - k < s.edge_no) begin
                @(negedge clk);
                if (cyc - k == 39) begin start = 1'b1; result = 2'd1; end
                if (cyc - k == 40) start = 1'b0;
            end
            checks++; if (matrix_player !== s.mp) begin errors++; $display("FAIL win2_player e=%0d got %h want %h", s.edge_no, matrix_player, s.mp); end
            checks++; if (matrix_pc !== s.mc) begin errors++; $display("FAIL win2_pc e=%0d got %h want %h", s.edge_no, matrix_pc, s.mc); end
            checks++; if (busy !== s.busy) begin errors++; $display("FAIL win2_busy e=%0d got %b want %b", s.edge_no, busy, s.busy); end
            checks++; if (done !== s.done) begin errors++; $display("FAIL win2_done e=%0d got %b want %b", s.edge_no, done, s.done); end
        end
    endtask

    task automatic test_abort;
        snap_t s;
        kick(2'd1);
        push_run(1, 1, 60);
        for (int e = 61; e <= 69; e++) begin
            s.edge_no = e; s.mp = '0; s.mc = '0; s.busy = 1'b0; s.done = 1'b0;
            sb.push_back(s);
        end
        while (sb.size() > 0) begin
            s = sb.pop_front();
            while (cyc - k < s.edge_no) begin
                @(negedge clk);
                abort = (cyc - k == 60);
            end
            checks++; if (matrix_player !== s.mp) begin errors++; $display("FAIL abort_player e=%0d got %h want %h", s.edge_no, matrix_player, s.mp); end
            checks++; if (matrix_pc !== s.mc) begin errors++; $display("FAIL abort_pc e=%0d got %h want %h", s.edge_no, matrix_pc, s.mc); end
            checks++; if (busy !== s.busy) begin errors++; $display("FAIL abort_busy e=%0d got %b want %b", s.edge_no, busy, s.busy); end
            checks++; if (done !== s.done) begin errors++; $display("FAIL abort_done e=%0d got %b want %b", s.edge_no, done, s.done); end
        end
        abort = 1'b0;
        test_player_win();
    endtask

    task automatic test_reset_mid;
        snap_t s;
        kick(2'd1);
        push_run(1, 1, 119);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            while (cyc - k < s.edge_no) @(negedge clk);
            checks++; if (matrix_pc !== s.mc) begin errors++; $display("FAIL rstmid_pc e=%0d got %h want %h", s.edge_no, matrix_pc, s.mc); end
            checks++; if (busy !== s.busy) begin errors++; $display("FAIL rstmid_busy e=%0d got %b want %b", s.edge_no, busy, s.busy); end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (matrix_pc !== '0) begin errors++; $display("FAIL async_rst_pc got %h want 0", matrix_pc); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_rst_busy got %b want 0", busy); end
        checks++; if (matrix_player !== '0) begin errors++; $display("FAIL async_rst_player got %h want 0", matrix_player); end
        repeat (2) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL async_rst_done got %b want 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
        test_player_win();
    endtask

    initial begin
        test_reset();
        test_player_win();
        test_clear();
        test_back_to_back();
        test_restart_ignored();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
